// File: rtl/ps2_kbd_io_port.sv
// PS/2 keyboard receiver with a scancode FIFO, exposed as DATA/STATUS registers on the CPU i/o bus.
// Reading DATA pops the head scancode; irq stays high while the FIFO holds anything.
module ps2_kbd_io_port #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned TIMEOUT    = 50000,
    parameter logic [8:0]  SEL        = 9'h000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] m_addr,
    input  logic [31:0] d_t_mem,
    input  logic        io_rdn,
    input  logic        io_wrn,
    output logic [31:0] io_data,
    output logic        irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StShift, StStop} state_t;

    logic [2:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic                  fall;
    logic                  bit_in;

    state_t                state_q;
    logic [3:0]            bitcnt_q;
    logic [7:0]            shift_q;
    logic                  parity_q;
    logic [TW-1:0]         to_q;

    logic                  frame_end;
    logic                  frame_good;
    logic                  push;
    logic                  bad_frame;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  overflow_q;
    logic                  frame_err_q;

    logic                  sel;
    logic                  ready;
    logic                  full;
    logic                  pop;
    logic                  do_push;
    logic                  status_wr;
    logic [7:0]            head_byte;
    logic [31:0]           data_reg;
    logic [31:0]           status_reg;
    logic                  unused_bits;

    assign unused_bits = ^{d_t_mem[31:4], d_t_mem[1:0], m_addr[28:12], m_addr[1:0]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign fall   = (clk_sync_q[2:1] == 2'b10);
    assign bit_in = data_sync_q[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= StIdle;
            bitcnt_q <= 4'd0;
            shift_q  <= 8'h00;
            parity_q <= 1'b0;
            to_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    to_q <= '0;
                    if (fall && !bit_in) begin
                        state_q  <= StShift;
                        bitcnt_q <= 4'd0;
                    end
                end
                StShift: begin
                    if (fall) begin
                        to_q <= '0;
                        if (bitcnt_q == 4'd8) begin
                            parity_q <= bit_in;
                            state_q  <= StStop;
                        end else begin
                            shift_q  <= {bit_in, shift_q[7:1]};
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end
                    end else if (to_q == TW'(TIMEOUT - 1)) begin
                        state_q <= StIdle;
                        to_q    <= '0;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end
                StStop: begin
                    if (fall) begin
                        state_q <= StIdle;
                        to_q    <= '0;
                    end else if (to_q == TW'(TIMEOUT - 1)) begin
                        state_q <= StIdle;
                        to_q    <= '0;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Odd parity over data+parity, and the stop bit must be high.
    assign frame_end  = (state_q == StStop) && fall;
    assign frame_good = bit_in && (^{shift_q, parity_q});
    assign push       = frame_end && frame_good;
    assign bad_frame  = frame_end && !frame_good;

    assign sel       = (m_addr[31:29] == 3'b101) && (m_addr[11:3] == SEL);
    assign ready     = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = !io_rdn && sel && !m_addr[2] && ready;
    assign do_push   = push && (!full || pop);
    assign status_wr = !io_wrn && sel && m_addr[2];
    assign count_d   = count_q + CW'(do_push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            // A fresh set takes priority over a same-cycle clear.
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (status_wr && d_t_mem[2]) begin
                overflow_q <= 1'b0;
            end
            if (bad_frame) begin
                frame_err_q <= 1'b1;
            end else if (status_wr && d_t_mem[3]) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign head_byte  = ready ? mem[rd_ptr_q] : 8'h00;
    assign data_reg   = {23'b0, ready, head_byte};
    assign status_reg = {24'b0, 4'(count_q), frame_err_q, overflow_q, full, ready};
    assign irq        = ready;

    always_comb begin
        io_data = 32'h0;
        if (!io_rdn && sel) begin
            io_data = m_addr[2] ? status_reg : data_reg;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_io_port.sv
// Directed bench for ps2_kbd_io_port: PS/2 frames driven bit by bit, CPU reads/writes checked
// against hand-computed register values.
module tb_ps2_kbd_io_port;

    localparam int unsigned TO = 400;
    localparam logic [31:0] DATA_A   = 32'hA000_0000;
    localparam logic [31:0] STATUS_A = 32'hA000_0004;

    logic        clk;
    logic        clrn;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] m_addr;
    logic [31:0] d_t_mem;
    logic        io_rdn;
    logic        io_wrn;
    logic [31:0] io_data;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    ps2_kbd_io_port #(
        .DEPTH_LOG2(3),
        .TIMEOUT   (TO),
        .SEL       (9'h000)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .m_addr  (m_addr),
        .d_t_mem (d_t_mem),
        .io_rdn  (io_rdn),
        .io_wrn  (io_wrn),
        .io_data (io_data),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit_fall(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_bit_rise();
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_bit_fall(b);
        ps2_bit_rise();
    endtask

    // Start, 8 data bits LSB first, parity (odd unless bad_par).
    task automatic send_head(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_head(b, bad_par);
        ps2_bit(~bad_stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] d);
        @(negedge clk);
        m_addr = addr;
        io_rdn = 1'b0;
        #1 d = io_data;
        @(negedge clk);
        io_rdn = 1'b1;
        m_addr = 32'h0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        m_addr  = addr;
        d_t_mem = d;
        io_wrn  = 1'b0;
        @(negedge clk);
        io_wrn  = 1'b1;
        m_addr  = 32'h0;
        d_t_mem = 32'h0;
    endtask

    initial begin
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        m_addr = 32'h0; d_t_mem = 32'h0; io_rdn = 1'b1; io_wrn = 1'b1;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        #1;
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_io_data", io_data, 32'h0);
        cpu_read(STATUS_A, rd);
        check("reset_status", rd, 32'h0);

        // Frame 0x1C with irq latency of exactly 3 clk edges after the stop fall.
        send_head(8'h1C, 1'b0);
        ps2_bit_fall(1'b1);
        @(posedge clk); @(posedge clk); #1;
        check("lat_irq_2edges", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        check("lat_irq_3edges", {31'b0, irq}, 32'h1);
        ps2_bit_rise();
        cpu_read(DATA_A, rd);
        check("t1_data", rd, 32'h0000_011C);
        cpu_read(DATA_A, rd);
        check("t1_data_empty", rd, 32'h0);
        #1 check("t1_irq_low", {31'b0, irq}, 32'h0);

        // Overflow: 9 frames into an 8-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        cpu_read(STATUS_A, rd);
        check("t2_status_full_ovf", rd, 32'h0000_0087);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(DATA_A, rd);
            check($sformatf("t2_data_%0d", i), rd, 32'h100 | i);
        end
        cpu_write(STATUS_A, 32'h4);
        cpu_read(STATUS_A, rd);
        check("t2_status_cleared", rd, 32'h0);

        // Bad parity, then bad stop bit.
        send_frame(8'h5A, 1'b1, 1'b0);
        cpu_read(STATUS_A, rd);
        check("t3_bad_parity", rd, 32'h0000_0008);
        cpu_write(STATUS_A, 32'h8);
        cpu_read(STATUS_A, rd);
        check("t3_ferr_cleared", rd, 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1);
        cpu_read(STATUS_A, rd);
        check("t3_bad_stop", rd, 32'h0000_0008);
        cpu_write(STATUS_A, 32'h8);

        // Full FIFO, pop in the same cycle as the 9th push.
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        send_head(8'h18, 1'b0);
        ps2_bit_fall(1'b1);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        m_addr = DATA_A;
        io_rdn = 1'b0;
        #1 rd = io_data;
        @(negedge clk);
        io_rdn = 1'b1;
        m_addr = 32'h0;
        check("t4_pop_push_head", rd, 32'h0000_0110);
        ps2_bit_rise();
        cpu_read(STATUS_A, rd);
        check("t4_status_no_ovf", rd, 32'h0000_0083);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(DATA_A, rd);
            check($sformatf("t4_drain_%0d", i), rd, 32'h110 + i);
        end
        for (int i = 0; i < 10; i++) begin
            send_frame(8'h40 + 8'(2 * i), 1'b0, 1'b0);
            send_frame(8'h41 + 8'(2 * i), 1'b0, 1'b0);
            cpu_read(DATA_A, rd);
            check($sformatf("t4_wrap_a%0d", i), rd, 32'h140 + 2 * i);
            cpu_read(DATA_A, rd);
            check($sformatf("t4_wrap_b%0d", i), rd, 32'h141 + 2 * i);
        end
        cpu_read(STATUS_A, rd);
        check("t4_status_end", rd, 32'h0);

        // Abandoned frame after 5 bits, then a clean 0x33.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h33, 1'b0, 1'b0);
        cpu_read(STATUS_A, rd);
        check("t5_status", rd, 32'h0000_0011);
        cpu_read(DATA_A, rd);
        check("t5_data", rd, 32'h0000_0133);

        // Reset mid-frame with 3 bytes queued.
        send_frame(8'h61, 1'b0, 1'b0);
        send_frame(8'h62, 1'b0, 1'b0);
        send_frame(8'h63, 1'b0, 1'b0);
        cpu_read(STATUS_A, rd);
        check("t6_pre_status", rd, 32'h0000_0031);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        clrn = 1'b0;
        #1 check("t6_irq", {31'b0, irq}, 32'h0);
        m_addr = STATUS_A;
        io_rdn = 1'b0;
        #1 check("t6_status_in_reset", io_data, 32'h0);
        io_rdn = 1'b1;
        m_addr = 32'h0;
        #1 check("t6_io_data", io_data, 32'h0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        cpu_read(STATUS_A, rd);
        check("t6_status_after", rd, 32'h0);
        send_frame(8'h29, 1'b0, 1'b0);
        cpu_read(DATA_A, rd);
        check("t6_data_29", rd, 32'h0000_0129);
        cpu_read(STATUS_A, rd);
        check("t6_status_end", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
